// File: rtl/apb_mem_slave_ws_pkg.sv
// Shared types and helpers for the wait-state APB memory completer.
// FSM state encoding, APB PPROT bit positions and a constant-evaluable clog2.
package apb_mem_slave_ws_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_state_t;

   localparam int PPROT_PRIV_BIT   = 0;
   localparam int PPROT_NONSEC_BIT = 1;
   localparam int PPROT_INSTR_BIT  = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_mem_slave_ws_if.sv
// APB4 completer-side bus bundle; clock and reset are routed separately.
// Requester holds address/control/data stable through the access phase.
interface apb_mem_slave_ws_if #(
   parameter int ADDWIDTH  = 10,
   parameter int DATAWIDTH = 32
);
   logic                   PSEL;
   logic                   PENABLE;
   logic                   PWRITE;
   logic [ADDWIDTH-1:0]    PADDR;
   logic [2:0]             PPROT;
   logic [DATAWIDTH/8-1:0] PSTRB;
   logic [DATAWIDTH-1:0]   PWDATA;
   logic                   PREADY;
   logic [DATAWIDTH-1:0]   PRDATA;
   logic                   PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PPROT, PSTRB, PWDATA,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PPROT, PSTRB, PWDATA,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apb_mem_slave_ws_ram.sv
// DEPTH x DATAWIDTH word array, per-byte write enables, one-cycle registered read.
// Read register returns to zero whenever no read is loaded, so it can drive PRDATA directly.
module apb_bytewise_ram
   import apb_mem_slave_ws_pkg::*;
#(
   parameter int DEPTH     = 256,
   parameter int DATAWIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [clog2(DEPTH)-1:0]   waddr,
   input  logic [DATAWIDTH/8-1:0]    wstrb,
   input  logic [DATAWIDTH-1:0]      wdata,
   input  logic                      re,
   input  logic [clog2(DEPTH)-1:0]   raddr,
   output logic [DATAWIDTH-1:0]      rdata
);
   logic [DATAWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DATAWIDTH/8; i++) begin
            if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
      else         rdata <= '0;
   end
endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB4 scratch RAM with WAIT_STATES programmable wait cycles and PSLVERR on misaligned,
// out-of-range or unprivileged-protected accesses; setup-to-PREADY latency 1+WAIT_STATES.
module apb_mem_slave_ws
   import apb_mem_slave_ws_pkg::*;
#(
   parameter int ADDWIDTH    = 10,
   parameter int DATAWIDTH   = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0,
   parameter int PROT_WORDS  = 0
) (
   input  logic PCLK,
   input  logic PRESETn,
   apb_mem_slave_ws_if.slave apb
);
   localparam int NBYTES = DATAWIDTH / 8;
   localparam int OFFW   = clog2(NBYTES);
   localparam int IDXW   = clog2(DEPTH);

   apb_state_t          state;
   logic [3:0]          wait_cnt;
   logic [IDXW-1:0]     cap_idx;
   logic                cap_err;
   logic                cap_write;
   logic                pready_q;
   logic                pslverr_q;

   logic [ADDWIDTH-1:0] dec_word;
   logic [IDXW-1:0]     dec_idx;
   logic                dec_mis, dec_range, dec_prot, dec_err;
   logic                setup;
   logic                rd_load, wr_commit;
   logic [IDXW-1:0]     rd_idx;
   logic                unused_prot;

   assign dec_word  = apb.PADDR >> OFFW;
   assign dec_idx   = dec_word[IDXW-1:0];
   assign dec_mis   = (apb.PADDR & ADDWIDTH'(NBYTES - 1)) != '0;
   assign dec_range = int'(dec_word) >= DEPTH;
   assign dec_prot  = apb.PWRITE && (int'(dec_word) < PROT_WORDS) && !apb.PPROT[PPROT_PRIV_BIT];
   assign dec_err   = dec_mis || dec_range || dec_prot;
   assign unused_prot = &{1'b0, apb.PPROT[PPROT_INSTR_BIT], apb.PPROT[PPROT_NONSEC_BIT]};

   assign setup = (state == IDLE) && apb.PSEL && !apb.PENABLE;

   // The read register loads on exactly the edge that raises PREADY.
   assign rd_load = PRESETn && (
                      (setup && (WAIT_STATES == 0) && !apb.PWRITE && !dec_err) ||
                      ((state == WAIT) && apb.PSEL && (wait_cnt == '0) && !cap_write && !cap_err));
   assign rd_idx  = (state == IDLE) ? dec_idx : cap_idx;

   assign wr_commit = PRESETn && (state == DONE) && apb.PSEL && apb.PENABLE &&
                      cap_write && !cap_err;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         cap_idx   <= '0;
         cap_err   <= 1'b0;
         cap_write <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (setup) begin
                  cap_idx   <= dec_idx;
                  cap_err   <= dec_err;
                  cap_write <= apb.PWRITE;
                  if (WAIT_STATES == 0) begin
                     state     <= DONE;
                     pready_q  <= 1'b1;
                     pslverr_q <= dec_err;
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= 4'(WAIT_STATES - 1);
                  end
               end
            end
            WAIT: begin
               if (!apb.PSEL) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
               end else if (wait_cnt == '0) begin
                  state     <= DONE;
                  pready_q  <= 1'b1;
                  pslverr_q <= cap_err;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: begin
               state     <= IDLE;
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
            end
         endcase
      end
   end

   apb_bytewise_ram #(
      .DEPTH     (DEPTH),
      .DATAWIDTH (DATAWIDTH)
   ) u_ram (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .we    (wr_commit),
      .waddr (cap_idx),
      .wstrb (apb.PSTRB),
      .wdata (apb.PWDATA),
      .re    (rd_load),
      .raddr (rd_idx),
      .rdata (apb.PRDATA)
   );

   assign apb.PREADY  = pready_q;
   assign apb.PSLVERR = pslverr_q;
endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Two completers (zero-wait 10-bit address, 3-wait 11-bit address, both 4 protected words)
// driven by one requester; a reference memory model feeds a scoreboard popped on PREADY.
module tb_apb_mem_slave_ws;

   logic PCLK = 1'b0;
   logic PRESETn;
   always #5 PCLK = ~PCLK;

   apb_mem_slave_ws_if #(.ADDWIDTH(10), .DATAWIDTH(32)) bus0 ();
   apb_mem_slave_ws_if #(.ADDWIDTH(11), .DATAWIDTH(32)) bus1 ();

   apb_mem_slave_ws #(.ADDWIDTH(10), .DATAWIDTH(32), .DEPTH(256), .WAIT_STATES(0), .PROT_WORDS(4))
      dut0 (.PCLK(PCLK), .PRESETn(PRESETn), .apb(bus0));
   apb_mem_slave_ws #(.ADDWIDTH(11), .DATAWIDTH(32), .DEPTH(256), .WAIT_STATES(3), .PROT_WORDS(4))
      dut1 (.PCLK(PCLK), .PRESETn(PRESETn), .apb(bus1));

   logic        psel, penable, pwrite;
   logic [10:0] paddr;
   logic [2:0]  pprot;
   logic [3:0]  pstrb;
   logic [31:0] pwdata;
   int          cur;

   assign bus0.PSEL    = psel && (cur == 0);
   assign bus0.PENABLE = penable;
   assign bus0.PWRITE  = pwrite;
   assign bus0.PADDR   = paddr[9:0];
   assign bus0.PPROT   = pprot;
   assign bus0.PSTRB   = pstrb;
   assign bus0.PWDATA  = pwdata;
   assign bus1.PSEL    = psel && (cur == 1);
   assign bus1.PENABLE = penable;
   assign bus1.PWRITE  = pwrite;
   assign bus1.PADDR   = paddr;
   assign bus1.PPROT   = pprot;
   assign bus1.PSTRB   = pstrb;
   assign bus1.PWDATA  = pwdata;

   logic        rdy  [2];
   logic [31:0] rdat [2];
   logic        err  [2];
   assign rdy[0]  = bus0.PREADY;
   assign rdy[1]  = bus1.PREADY;
   assign rdat[0] = bus0.PRDATA;
   assign rdat[1] = bus1.PRDATA;
   assign err[0]  = bus0.PSLVERR;
   assign err[1]  = bus1.PSLVERR;

   typedef struct packed {
      logic        rd;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] mem_m [2][256];
   int          ws_m [2] = '{0, 3};
   int          vectors = 0;
   int          miscompares = 0;
   bit          mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: every PREADY cycle consumes one expected response.
   always @(negedge PCLK) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            if (rdy[d]) begin
               exp_t e;
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_pready dut%0d: PREADY=1, expected 0", d);
               end else begin
                  e = (d == 0) ? q0.pop_front() : q1.pop_front();
                  check($sformatf("pslverr dut%0d", d), 32'(err[d]), 32'(e.err));
                  if (e.rd) check($sformatf("prdata dut%0d", d), rdat[d], e.data);
               end
            end else begin
               check($sformatf("idle_prdata dut%0d", d), rdat[d], 32'h0);
               check($sformatf("idle_pslverr dut%0d", d), 32'(err[d]), 32'h0);
            end
         end
      end
   end

   task automatic xfer(input int d, input logic wr, input logic [10:0] a_in, input logic [2:0] prot,
                       input logic [3:0] strb, input logic [31:0] wd, input bit abort_rst);
      exp_t        e;
      logic [10:0] a;
      int          idx, cyc;
      bit          er, got;
      a = (d == 0) ? (a_in & 11'h3FF) : a_in;
      @(posedge PCLK); #1;
      cur = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
      pprot = prot; pstrb = strb; pwdata = wd;
      idx = int'(a) / 4;
      er  = (a % 4 != 0) || (idx >= 256) || (wr && idx < 4 && !prot[0]);
      e.rd   = !wr;
      e.err  = er;
      e.data = (!wr && !er) ? mem_m[d][idx] : 32'h0;
      if (!abort_rst) begin
         if (d == 0) q0.push_back(e); else q1.push_back(e);
         if (wr && !er)
            for (int b = 0; b < 4; b++)
               if (strb[b]) mem_m[d][idx][b*8 +: 8] = wd[b*8 +: 8];
      end
      @(posedge PCLK); #1;
      penable = 1'b1;
      if (abort_rst) begin
         @(negedge PCLK);
         check("abort_pre_pready", 32'(rdy[d]), 32'h0);
         @(posedge PCLK); #1;
         PRESETn = 1'b0;
         @(posedge PCLK); #1;
         PRESETn = 1'b1; psel = 1'b0; penable = 1'b0;
         @(negedge PCLK);
         check("abort_pready", 32'(rdy[d]), 32'h0);
         check("abort_prdata", rdat[d], 32'h0);
         check("abort_pslverr", 32'(err[d]), 32'h0);
         return;
      end
      cyc = 1; got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge PCLK);
         if (rdy[d]) got = 1'b1;
         else        cyc++;
      end
      check($sformatf("latency dut%0d", d), 32'(cyc), 32'(ws_m[d] + 1));
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      PRESETn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
      pprot = '0; pstrb = '0; pwdata = '0; cur = 0;
      repeat (3) @(posedge PCLK);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_pready dut%0d", d), 32'(rdy[d]), 32'h0);
         check($sformatf("reset_prdata dut%0d", d), rdat[d], 32'h0);
         check($sformatf("reset_pslverr dut%0d", d), 32'(err[d]), 32'h0);
      end
      PRESETn = 1'b1;
      mon_en  = 1'b1;

      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 256; w++)
            xfer(d, 1'b1, 11'(w * 4), 3'b001, 4'hF, $urandom, 1'b0);

      xfer(0, 1'b1, 11'h010, 3'b000, 4'hF, 32'hA5A5_1234, 1'b0);
      xfer(0, 1'b0, 11'h010, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(0, 1'b1, 11'h000, 3'b001, 4'hF, 32'h0, 1'b0);
      xfer(0, 1'b1, 11'h000, 3'b001, 4'b0101, 32'hFFFF_FFFF, 1'b0);
      xfer(0, 1'b0, 11'h000, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(1, 1'b0, 11'h020, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(1, 1'b0, 11'h400, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(1, 1'b0, 11'h013, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(0, 1'b0, 11'h013, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(1, 1'b0, 11'h010, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(0, 1'b1, 11'h008, 3'b000, 4'hF, 32'hDEAD_BEEF, 1'b0);
      xfer(0, 1'b0, 11'h008, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(0, 1'b1, 11'h008, 3'b001, 4'hF, 32'hDEAD_BEEF, 1'b0);
      xfer(0, 1'b0, 11'h008, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(1, 1'b1, 11'h044, 3'b000, 4'h0, 32'h1234_5678, 1'b0);
      xfer(1, 1'b0, 11'h044, 3'b000, 4'h0, 32'h0, 1'b0);
      xfer(1, 1'b1, 11'h030, 3'b000, 4'hF, 32'h0BAD_F00D, 1'b1);
      xfer(1, 1'b0, 11'h030, 3'b000, 4'h0, 32'h0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         int          d;
         logic [10:0] a;
         d = int'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) a = 11'($urandom_range(0, 11'h7FF));
         else                           a = 11'($urandom_range(0, 255) * 4);
         xfer(d, 1'($urandom), a, 3'($urandom), 4'($urandom), $urandom, 1'b0);
      end

      repeat (5) @(posedge PCLK);
      check("drain_q0", 32'(q0.size()), 32'h0);
      check("drain_q1", 32'(q1.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
